// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_pkg;

  typedef enum logic {TS_IDLE, TS_TRAP} trap_state_t;

  localparam int unsigned ECALL_CAUSE    = 11;
  localparam int unsigned MCAUSE_INT_BIT = 31;

  // Index width that stays legal when only one source exists.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest-index asserted request wins.
module irq_prio_enc
  import trap_pkg::*;
#(
  parameter int unsigned N  = 4,
  localparam int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i] && !valid) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_trap_ctrl.sv
// Machine-mode trap controller: per-source edge/level capture, enable masking,
// fixed-priority selection and a single-level IDLE/TRAP sequencer.
module irq_trap_ctrl
  import trap_pkg::*;
#(
  parameter int unsigned          NUM_IRQ    = 4,
  parameter logic [NUM_IRQ-1:0]   EDGE_MASK  = 4'b0001,
  parameter int unsigned          CAUSE_BASE = 16
) (
  input  logic               clk,
  input  logic               Rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               mie,
  input  logic               ecall,
  input  logic               trap_ret,
  input  logic               mem_hold,
  output logic               trapping,
  output logic               trigger_trap,
  output logic               trigger_trap_ret,
  output logic [31:0]        mcause,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               nest_err
);

  localparam int unsigned IW = idx_width(NUM_IRQ);

  trap_state_t        state, state_n;
  logic [NUM_IRQ-1:0] irq_q, pending, pending_n, clr_q, clr_n, req;
  logic               trig_q, trig_n, ret_q, ret_n, nest_q, nest_n;
  logic [31:0]        mcause_q, mcause_n;
  logic               req_valid;
  logic [IW-1:0]      req_idx;

  assign req = pending & irq_en & {NUM_IRQ{mie}};

  irq_prio_enc #(.N(NUM_IRQ)) u_prio_enc (
    .req   (req),
    .valid (req_valid),
    .idx   (req_idx)
  );

  // clr_q marks the interrupt source taken last cycle; a new edge still wins.
  always_comb begin
    pending_n = pending;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (EDGE_MASK[i]) pending_n[i] = (irq[i] & ~irq_q[i]) | (pending[i] & ~clr_q[i]);
      else              pending_n[i] = irq[i];
    end
  end

  always_comb begin
    state_n  = state;
    trig_n   = 1'b0;
    ret_n    = 1'b0;
    clr_n    = '0;
    mcause_n = mcause_q;
    nest_n   = nest_q;
    if (!mem_hold) begin
      unique case (state)
        TS_IDLE: begin
          if (req_valid) begin
            state_n  = TS_TRAP;
            trig_n   = 1'b1;
            clr_n    = NUM_IRQ'(1) << req_idx;
            mcause_n = '0;
            mcause_n[MCAUSE_INT_BIT] = 1'b1;
            mcause_n[30:0] = 31'(CAUSE_BASE + 32'(req_idx));
          end else if (ecall) begin
            state_n  = TS_TRAP;
            trig_n   = 1'b1;
            mcause_n = 32'(ECALL_CAUSE);
          end
        end
        TS_TRAP: begin
          if (ecall) nest_n = 1'b1;
          if (trap_ret) begin
            state_n = TS_IDLE;
            ret_n   = 1'b1;
          end
        end
        default: state_n = TS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state    <= TS_IDLE;
      irq_q    <= '0;
      pending  <= '0;
      clr_q    <= '0;
      trig_q   <= 1'b0;
      ret_q    <= 1'b0;
      mcause_q <= '0;
      nest_q   <= 1'b0;
    end else begin
      state    <= state_n;
      irq_q    <= irq;
      pending  <= pending_n;
      clr_q    <= clr_n;
      trig_q   <= trig_n;
      ret_q    <= ret_n;
      mcause_q <= mcause_n;
      nest_q   <= nest_n;
    end
  end

  assign trapping         = (state == TS_TRAP);
  assign trigger_trap     = trig_q & ~mem_hold;
  assign trigger_trap_ret = ret_q & ~mem_hold;
  assign mcause           = mcause_q;
  assign irq_pending      = pending;
  assign nest_err         = nest_q;

endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Self-checking bench for irq_trap_ctrl: per-cycle vectors with a scoreboard queue.
module tb_irq_trap_ctrl;

  logic        clk = 1'b0;
  logic        Rst;
  logic [3:0]  irq, irq_en;
  logic        mie, ecall, trap_ret, mem_hold;
  logic        trapping, trigger_trap, trigger_trap_ret, nest_err;
  logic [31:0] mcause;
  logic [3:0]  irq_pending;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] CE = 32'h0000000B;
  localparam logic [31:0] I0 = 32'h80000010;
  localparam logic [31:0] I1 = 32'h80000011;
  localparam logic [31:0] I2 = 32'h80000012;

  always #5 clk = ~clk;

  irq_trap_ctrl #(.NUM_IRQ(4), .EDGE_MASK(4'b0001), .CAUSE_BASE(16)) dut (
    .clk              (clk),
    .Rst              (Rst),
    .irq              (irq),
    .irq_en           (irq_en),
    .mie              (mie),
    .ecall            (ecall),
    .trap_ret         (trap_ret),
    .mem_hold         (mem_hold),
    .trapping         (trapping),
    .trigger_trap     (trigger_trap),
    .trigger_trap_ret (trigger_trap_ret),
    .mcause           (mcause),
    .irq_pending      (irq_pending),
    .nest_err         (nest_err)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  irq;
    logic [3:0]  en;
    logic        mie;
    logic        ecall;
    logic        ret;
    logic        hold;
    logic        e_trap;
    logic        e_trig;
    logic        e_ret;
    logic [31:0] e_mcause;
    logic [3:0]  e_pend;
    logic        e_nest;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   step_no = 0;

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [3:0] en,
                              input logic m, input logic ec, input logic rt, input logic h,
                              input logic et, input logic eg, input logic er,
                              input logic [31:0] mc, input logic [3:0] pd, input logic ne);
    vec_t v;
    v.rst = r; v.irq = q; v.en = en; v.mie = m; v.ecall = ec; v.ret = rt; v.hold = h;
    v.e_trap = et; v.e_trig = eg; v.e_ret = er; v.e_mcause = mc; v.e_pend = pd; v.e_nest = ne;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step %0d %s: got %h expected %h", step_no, name, act, exp);
    end
  endtask

  // Inputs for a cycle are applied just after the rising edge and outputs are
  // sampled mid-cycle, so each record holds the outputs seen in that same cycle.
  task automatic step(input vec_t v);
    vec_t e;
    @(posedge clk); #1;
    Rst = v.rst; irq = v.irq; irq_en = v.en; mie = v.mie;
    ecall = v.ecall; trap_ret = v.ret; mem_hold = v.hold;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk("trapping",         32'(trapping),         32'(e.e_trap));
    chk("trigger_trap",     32'(trigger_trap),     32'(e.e_trig));
    chk("trigger_trap_ret", 32'(trigger_trap_ret), 32'(e.e_ret));
    chk("mcause",           mcause,                e.e_mcause);
    chk("irq_pending",      32'(irq_pending),      32'(e.e_pend));
    chk("nest_err",         32'(nest_err),         32'(e.e_nest));
    step_no++;
  endtask

  task automatic hs(input logic [3:0] q, input logic ec, input logic rt, input logic h,
                    input logic r, input logic et, input logic eg, input logic er,
                    input logic [31:0] mc, input logic [3:0] pd, input logic ne);
    step(mk(r, q, 4'hF, 1'b1, ec, rt, h, et, eg, er, mc, pd, ne));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Idle after reset: everything zero
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 4'h0, 4'hF, 1, 0, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0));
    // ecall entry and mret
    tbl.push_back(mk(0, 4'h0, 4'hF, 1, 1, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 1, 0, 0, 0, 1, 1, 0, CE, 4'h0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 4'h0, 4'hF, 1, 0, 0, 0, 1, 0, 0, CE, 4'h0, 0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 1, 0, 1, 0, 1, 0, 0, CE, 4'h0, 0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 1, 0, 0, 0, 0, 0, 1, CE, 4'h0, 0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 1, 0, 0, 0, 0, 0, 0, CE, 4'h0, 0));
    // mret while idle is ignored
    tbl.push_back(mk(0, 4'h0, 4'hF, 1, 0, 1, 0, 0, 0, 0, CE, 4'h0, 0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 1, 0, 0, 0, 0, 0, 0, CE, 4'h0, 0));
    // ecall under mem_hold is dropped, not deferred
    tbl.push_back(mk(0, 4'h0, 4'hF, 1, 1, 0, 1, 0, 0, 0, CE, 4'h0, 0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 1, 0, 0, 0, 0, 0, 0, CE, 4'h0, 0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 1, 0, 0, 0, 0, 0, 0, CE, 4'h0, 0));
    // global enable off: pending visible, no trap
    tbl.push_back(mk(0, 4'h2, 4'hF, 0, 0, 0, 0, 0, 0, 0, CE, 4'h0, 0));
    tbl.push_back(mk(0, 4'h2, 4'hF, 0, 0, 0, 0, 0, 0, 0, CE, 4'h2, 0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 0, 0, 0, 0, 0, 0, 0, CE, 4'h2, 0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 1, 0, 0, 0, 0, 0, 0, CE, 4'h0, 0));
    // per-source enable off for source 2
    tbl.push_back(mk(0, 4'h4, 4'hB, 1, 0, 0, 0, 0, 0, 0, CE, 4'h0, 0));
    tbl.push_back(mk(0, 4'h4, 4'hB, 1, 0, 0, 0, 0, 0, 0, CE, 4'h4, 0));
    tbl.push_back(mk(0, 4'h0, 4'hB, 1, 0, 0, 0, 0, 0, 0, CE, 4'h4, 0));
    tbl.push_back(mk(0, 4'h0, 4'hF, 1, 0, 0, 0, 0, 0, 0, CE, 4'h0, 0));

    Rst = 1'b1; irq = '0; irq_en = 4'hF; mie = 1'b1;
    ecall = 1'b0; trap_ret = 1'b0; mem_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[k]) step(tbl[k]);

    // Priority: src1 before src2, src2 one cycle after the return pulse
    hs(4'h6, 0, 0, 0, 0, 0, 0, 0, CE, 4'h0, 0);
    hs(4'h6, 0, 0, 0, 0, 0, 0, 0, CE, 4'h6, 0);
    hs(4'h4, 0, 0, 0, 0, 1, 1, 0, I1, 4'h6, 0);
    hs(4'h4, 0, 0, 0, 0, 1, 0, 0, I1, 4'h4, 0);
    hs(4'h4, 0, 1, 0, 0, 1, 0, 0, I1, 4'h4, 0);
    hs(4'h4, 0, 0, 0, 0, 0, 0, 1, I1, 4'h4, 0);
    hs(4'h0, 0, 0, 0, 0, 1, 1, 0, I2, 4'h4, 0);
    hs(4'h0, 0, 0, 0, 0, 1, 0, 0, I2, 4'h0, 0);
    hs(4'h0, 0, 1, 0, 0, 1, 0, 0, I2, 4'h0, 0);
    hs(4'h0, 0, 0, 0, 0, 0, 0, 1, I2, 4'h0, 0);
    hs(4'h0, 0, 0, 0, 0, 0, 0, 0, I2, 4'h0, 0);

    // Edge source pulsed during a trap stays pending, cleared once taken
    hs(4'h0, 1, 0, 0, 0, 0, 0, 0, I2, 4'h0, 0);
    hs(4'h1, 0, 0, 0, 0, 1, 1, 0, CE, 4'h0, 0);
    hs(4'h0, 0, 0, 0, 0, 1, 0, 0, CE, 4'h1, 0);
    hs(4'h0, 0, 0, 0, 0, 1, 0, 0, CE, 4'h1, 0);
    hs(4'h0, 0, 1, 0, 0, 1, 0, 0, CE, 4'h1, 0);
    hs(4'h0, 0, 0, 0, 0, 0, 0, 1, CE, 4'h1, 0);
    hs(4'h0, 0, 0, 0, 0, 1, 1, 0, I0, 4'h1, 0);
    hs(4'h0, 0, 0, 0, 0, 1, 0, 0, I0, 4'h0, 0);
    hs(4'h0, 0, 1, 0, 0, 1, 0, 0, I0, 4'h0, 0);
    hs(4'h0, 0, 0, 0, 0, 0, 0, 1, I0, 4'h0, 0);
    hs(4'h0, 0, 0, 0, 0, 0, 0, 0, I0, 4'h0, 0);

    // irq0 + ecall under 3 cycles of mem_hold; interrupt wins; nested ecall
    hs(4'h1, 1, 0, 1, 0, 0, 0, 0, I0, 4'h0, 0);
    hs(4'h1, 1, 0, 1, 0, 0, 0, 0, I0, 4'h1, 0);
    hs(4'h1, 1, 0, 1, 0, 0, 0, 0, I0, 4'h1, 0);
    hs(4'h1, 1, 0, 0, 0, 0, 0, 0, I0, 4'h1, 0);
    hs(4'h0, 0, 0, 0, 0, 1, 1, 0, I0, 4'h1, 0);
    hs(4'h0, 1, 0, 0, 0, 1, 0, 0, I0, 4'h0, 0);
    hs(4'h0, 0, 0, 0, 0, 1, 0, 0, I0, 4'h0, 1);
    hs(4'h0, 0, 1, 0, 0, 1, 0, 0, I0, 4'h0, 1);
    hs(4'h0, 0, 0, 0, 0, 0, 0, 1, I0, 4'h0, 1);
    hs(4'h0, 0, 0, 0, 0, 0, 0, 0, I0, 4'h0, 1);

    // Reset mid-trap with a level source held high
    hs(4'h2, 0, 0, 0, 0, 0, 0, 0, I0, 4'h0, 1);
    hs(4'h2, 0, 0, 0, 0, 0, 0, 0, I0, 4'h2, 1);
    hs(4'h2, 0, 0, 0, 0, 1, 1, 0, I1, 4'h2, 1);
    hs(4'h2, 0, 0, 0, 1, 1, 0, 0, I1, 4'h2, 1);
    hs(4'h2, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0);
    hs(4'h2, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'h2, 0);
    hs(4'h2, 0, 0, 0, 0, 1, 1, 0, I1, 4'h2, 0);

    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
